// File: rtl/counter_wrap_monitor.sv
// counter_wrap_monitor
//   Watches an 8-bit accumulating counter, detects modulo-256 wrap-arounds,
//   recovers the increment that caused each wrap and timestamps it against a
//   free-running cycle counter. Wrap events are queued in a small FIFO that a
//   consumer drains with a valid/ready handshake. Events arriving while the
//   FIFO is full are dropped and reported through a sticky overflow flag.
//
// Ports
//   clk            single clock, all state on posedge
//   rst            asynchronous active-high reset
//   counter_value  sampled counter from the upstream stage
//   evt_ready      consumer accepts the head event this cycle
//   ovf_clear      synchronous clear of the sticky overflow flag
//   evt_valid      FIFO non-empty, head event presented
//   evt_timestamp  timestamp of the head event
//   evt_delta      increment that caused the head wrap
//   fifo_level     current occupancy, 0..DEPTH
//   wrap_count     total wraps detected, including dropped ones
//   overflow       sticky: at least one event was dropped
module counter_wrap_monitor #(
    parameter int DEPTH    = 4,
    parameter int TS_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 counter_value,
    input  logic                       evt_ready,
    input  logic                       ovf_clear,
    output logic                       evt_valid,
    output logic [TS_WIDTH-1:0]        evt_timestamp,
    output logic [7:0]                 evt_delta,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic [TS_WIDTH-1:0]        wrap_count,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    logic [7:0]          prev_value;
    logic                prev_valid;
    logic [TS_WIDTH-1:0] ts;

    logic [TS_WIDTH-1:0] ts_mem    [DEPTH];
    logic [7:0]          delta_mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [LVL_W-1:0]    level;

    logic       wrap;
    logic [7:0] delta;
    logic       pop;
    logic       push;
    logic       drop;

    // A wrap is a step backwards in unsigned terms; the modular difference is
    // then exactly the increment that carried the counter past 255.
    always_comb begin
        wrap  = prev_valid && (counter_value < prev_value);
        delta = counter_value - prev_value;
        pop   = evt_valid && evt_ready;
        // A pop on the same edge frees a slot, so a full FIFO still accepts.
        push  = wrap && ((level != FULL_LEVEL) || pop);
        drop  = wrap && (level == FULL_LEVEL) && !pop;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_value <= '0;
            prev_valid <= 1'b0;
            ts         <= '0;
            wrap_count <= '0;
            overflow   <= 1'b0;
        end else begin
            prev_value <= counter_value;
            prev_valid <= 1'b1;
            ts         <= ts + TS_WIDTH'(1);
            if (wrap) begin
                wrap_count <= wrap_count + TS_WIDTH'(1);
            end
            // A drop outranks a clear on the same edge so no loss goes unseen.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    // NOTE: the storage array is reset because the head outputs read it
    // directly and must show zero after reset; at this depth the cost is tiny.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ts_mem[i]    <= '0;
                delta_mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                ts_mem[wr_ptr]    <= ts;
                delta_mem[wr_ptr] <= delta;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    assign evt_valid     = (level != '0);
    assign evt_timestamp = ts_mem[rd_ptr];
    assign evt_delta     = delta_mem[rd_ptr];
    assign fifo_level    = level;

endmodule

// File: tb/tb_counter_wrap_monitor.sv
module tb_counter_wrap_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  counter_value = '0;
    logic        evt_ready = 1'b0;
    logic        ovf_clear = 1'b0;
    logic        evt_valid;
    logic [15:0] evt_timestamp;
    logic [7:0]  evt_delta;
    logic [2:0]  fifo_level;
    logic [15:0] wrap_count;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    counter_wrap_monitor #(.DEPTH(4), .TS_WIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .counter_value (counter_value),
        .evt_ready     (evt_ready),
        .ovf_clear     (ovf_clear),
        .evt_valid     (evt_valid),
        .evt_timestamp (evt_timestamp),
        .evt_delta     (evt_delta),
        .fifo_level    (fifo_level),
        .wrap_count    (wrap_count),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [7:0] v, input logic rdy, input logic clr);
        counter_value = v;
        evt_ready     = rdy;
        ovf_clear     = clr;
        step();
    endtask

    task automatic do_reset();
        counter_value = '0;
        evt_ready     = 1'b0;
        ovf_clear     = 1'b0;
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_cmp++;
        if ({evt_valid, fifo_level, wrap_count, overflow, evt_timestamp, evt_delta} !== 45'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%0b lvl=%0d wc=%0d ovf=%0b ts=%0d d=%0d, want all 0",
                     evt_valid, fifo_level, wrap_count, overflow, evt_timestamp, evt_delta);
        end
        rst = 1'b0;
    endtask

    task automatic test_no_wrap();
        apply(8'd120, 1'b0, 1'b0);
        apply(8'd130, 1'b0, 1'b0);
        apply(8'd140, 1'b0, 1'b0);
        n_cmp++;
        if (evt_valid !== 1'b0 || wrap_count !== 16'd0) begin
            n_bad++;
            $display("FAIL no_wrap: got valid=%0b wc=%0d, want 0/0", evt_valid, wrap_count);
        end
    endtask

    task automatic test_single_wrap();
        apply(8'd250, 1'b0, 1'b0);
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_pre: got valid=%0b, want 0", evt_valid);
        end
        apply(8'd4, 1'b0, 1'b0);
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_delta !== 8'd10 || evt_timestamp !== 16'd4 ||
            wrap_count !== 16'd1 || fifo_level !== 3'd1) begin
            n_bad++;
            $display("FAIL single_wrap: got valid=%0b d=%0d ts=%0d wc=%0d lvl=%0d, want 1/10/4/1/1",
                     evt_valid, evt_delta, evt_timestamp, wrap_count, fifo_level);
        end
    endtask

    task automatic test_overflow_drain();
        logic [15:0] exp_ts [4] = '{16'd1, 16'd3, 16'd5, 16'd7};
        do_reset();
        apply(8'd200, 1'b0, 1'b0);             // priming edge, ts 0
        for (int i = 0; i < 4; i++) begin
            apply(8'd10, 1'b0, 1'b0);
            apply(8'd200, 1'b0, 1'b0);
        end
        n_cmp++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0 || wrap_count !== 16'd4) begin
            n_bad++;
            $display("FAIL fill4: got lvl=%0d ovf=%0b wc=%0d, want 4/0/4", fifo_level, overflow, wrap_count);
        end
        apply(8'd10, 1'b0, 1'b0);              // fifth wrap, dropped
        n_cmp++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1 || wrap_count !== 16'd5) begin
            n_bad++;
            $display("FAIL overflow5: got lvl=%0d ovf=%0b wc=%0d, want 4/1/5", fifo_level, overflow, wrap_count);
        end
        apply(8'd10, 1'b0, 1'b0);              // stall: head must hold
        n_cmp++;
        if (evt_timestamp !== 16'd1 || evt_delta !== 8'd66 || fifo_level !== 3'd4) begin
            n_bad++;
            $display("FAIL hold: got ts=%0d d=%0d lvl=%0d, want 1/66/4", evt_timestamp, evt_delta, fifo_level);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (evt_valid !== 1'b1 || evt_timestamp !== exp_ts[i] || evt_delta !== 8'd66) begin
                n_bad++;
                $display("FAIL drain%0d: got v=%0b ts=%0d d=%0d, want 1/%0d/66",
                         i, evt_valid, evt_timestamp, evt_delta, exp_ts[i]);
            end
            apply(8'd10, 1'b1, 1'b0);
        end
        n_cmp++;
        if (evt_valid !== 1'b0 || fifo_level !== 3'd0) begin
            n_bad++;
            $display("FAIL drained: got v=%0b lvl=%0d, want 0/0", evt_valid, fifo_level);
        end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] exp_ts [4] = '{16'd19, 16'd21, 16'd23, 16'd25};
        apply(8'd10, 1'b0, 1'b1);              // clear sticky flag, no drop
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clear: got %0b, want 0", overflow);
        end
        for (int i = 0; i < 4; i++) begin      // wraps at ts 17,19,21,23
            apply(8'd200, 1'b0, 1'b0);
            apply(8'd10, 1'b0, 1'b0);
        end
        apply(8'd200, 1'b0, 1'b0);
        apply(8'd10, 1'b1, 1'b0);              // wrap at ts 25 with pop
        n_cmp++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0 || wrap_count !== 16'd10) begin
            n_bad++;
            $display("FAIL full_push_pop: got lvl=%0d ovf=%0b wc=%0d, want 4/0/10", fifo_level, overflow, wrap_count);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (evt_valid !== 1'b1 || evt_timestamp !== exp_ts[i] || evt_delta !== 8'd66) begin
                n_bad++;
                $display("FAIL order%0d: got v=%0b ts=%0d d=%0d, want 1/%0d/66",
                         i, evt_valid, evt_timestamp, evt_delta, exp_ts[i]);
            end
            apply(8'd10, 1'b1, 1'b0);
        end
    endtask

    task automatic test_drop_vs_clear();
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin      // wraps at ts 31,33,35,37
            apply(8'd200, 1'b0, 1'b0);
            apply(8'd10, 1'b0, 1'b0);
        end
        apply(8'd200, 1'b0, 1'b0);
        apply(8'd10, 1'b0, 1'b1);              // drop and clear together
        n_cmp++;
        if (overflow !== 1'b1 || fifo_level !== 3'd4 || wrap_count !== 16'd15 || evt_timestamp !== 16'd31) begin
            n_bad++;
            $display("FAIL drop_wins: got ovf=%0b lvl=%0d wc=%0d ts=%0d, want 1/4/15/31",
                     overflow, fifo_level, wrap_count, evt_timestamp);
        end
        apply(8'd10, 1'b0, 1'b1);
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_after: got ovf=%0b, want 0", overflow);
        end
    endtask

    task automatic test_reset_mid();
        apply(8'd10, 1'b1, 1'b0);
        evt_ready = 1'b0;
        n_cmp++;
        if (fifo_level !== 3'd3 || evt_timestamp !== 16'd33) begin
            n_bad++;
            $display("FAIL pre_reset: got lvl=%0d ts=%0d, want 3/33", fifo_level, evt_timestamp);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({evt_valid, fifo_level, wrap_count, overflow, evt_timestamp, evt_delta} !== 45'd0) begin
            n_bad++;
            $display("FAIL async_reset: got valid=%0b lvl=%0d wc=%0d ovf=%0b ts=%0d d=%0d, want all 0",
                     evt_valid, fifo_level, wrap_count, overflow, evt_timestamp, evt_delta);
        end
        rst = 1'b0;
        apply(8'd5, 1'b0, 1'b0);
        n_cmp++;
        if (evt_valid !== 1'b0 || wrap_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reprime: got v=%0b wc=%0d, want 0/0", evt_valid, wrap_count);
        end
        apply(8'd2, 1'b0, 1'b0);
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_delta !== 8'd253 || wrap_count !== 16'd1 || evt_timestamp !== 16'd1) begin
            n_bad++;
            $display("FAIL post_reset_wrap: got v=%0b d=%0d wc=%0d ts=%0d, want 1/253/1/1",
                     evt_valid, evt_delta, wrap_count, evt_timestamp);
        end
    endtask

    task automatic test_boundary();
        do_reset();
        apply(8'd0, 1'b0, 1'b0);               // prime, ts 0
        apply(8'd255, 1'b0, 1'b0);             // +255, no wrap
        apply(8'd255, 1'b0, 1'b0);             // equal, no wrap
        n_cmp++;
        if (evt_valid !== 1'b0 || wrap_count !== 16'd0) begin
            n_bad++;
            $display("FAIL step255_equal: got v=%0b wc=%0d, want 0/0", evt_valid, wrap_count);
        end
        apply(8'd0, 1'b0, 1'b0);               // 255 -> 0 wraps at ts 3
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_delta !== 8'd1 || evt_timestamp !== 16'd3 || wrap_count !== 16'd1) begin
            n_bad++;
            $display("FAIL wrap_by_one: got v=%0b d=%0d ts=%0d wc=%0d, want 1/1/3/1",
                     evt_valid, evt_delta, evt_timestamp, wrap_count);
        end
        apply(8'd0, 1'b1, 1'b0);               // pop, counter equal
        apply(8'd0, 1'b1, 1'b0);               // ready while empty: no effect
        n_cmp++;
        if (evt_valid !== 1'b0 || fifo_level !== 3'd0) begin
            n_bad++;
            $display("FAIL ready_empty: got v=%0b lvl=%0d, want 0/0", evt_valid, fifo_level);
        end
    endtask

    initial begin
        test_reset();
        test_no_wrap();
        test_single_wrap();
        test_overflow_drain();
        test_full_push_pop();
        test_drop_vs_clear();
        test_reset_mid();
        test_boundary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1);
    end

endmodule
